// File: rtl/pitch_pkg.sv
// rtl/pitch_pkg.sv - shared widths, constants and FSM encoding for the pitch peak picker
package pitch_pkg;
    localparam int SUM_W         = 36;
    localparam int LAG_W         = 10;
    localparam int THR_DEN_SHIFT = 3;
    localparam int CMP_W         = SUM_W + 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEEK  = 2'd1,
        ST_TRACK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/autocorr_peak_picker_if.sv
// rtl/autocorr_peak_picker_if.sv - correlation-sum input stream and pitch result output bus
interface autocorr_peak_picker_if;
    import pitch_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [SUM_W-1:0] in_sum;
    logic                    in_first;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [LAG_W-1:0]        pitch_lag;
    logic signed [SUM_W-1:0] peak_sum;
    logic                    pitch_found;

    modport master (
        output in_valid, in_sum, in_first, in_last, out_ready,
        input  in_ready, out_valid, pitch_lag, peak_sum, pitch_found
    );

    modport slave (
        input  in_valid, in_sum, in_first, in_last, out_ready,
        output in_ready, out_valid, pitch_lag, peak_sum, pitch_found
    );
endinterface

// File: rtl/peak_threshold_cmp.sv
// rtl/peak_threshold_cmp.sv - signed check best*2^THR_DEN_SHIFT >= r0*THR_NUM
module peak_threshold_cmp
    import pitch_pkg::*;
#(
    parameter int THR_NUM = 5
) (
    input  logic signed [SUM_W-1:0] best,
    input  logic signed [SUM_W-1:0] r0,
    output logic                    ge
);
    logic signed [CMP_W-1:0] best_scaled;
    logic signed [CMP_W-1:0] r0_scaled;

    always_comb begin
        best_scaled = CMP_W'(best) <<< THR_DEN_SHIFT;
        r0_scaled   = CMP_W'(r0) * CMP_W'(signed'(THR_NUM));
        ge          = (best_scaled >= r0_scaled);
    end
endmodule

// File: rtl/autocorr_peak_picker.sv
// rtl/autocorr_peak_picker.sv - picks the pitch lag from per-lag autocorrelation sums, one result per frame
module autocorr_peak_picker
    import pitch_pkg::*;
#(
    parameter int MIN_LAG = 20,
    parameter int MAX_LAG = 400,
    parameter int THR_NUM = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    autocorr_peak_picker_if.slave   bus
);
    localparam logic [LAG_W-1:0] MIN_L = LAG_W'(MIN_LAG);
    localparam logic [LAG_W-1:0] MAX_L = LAG_W'(MAX_LAG);

    state_e                  state_q, state_d;
    logic [LAG_W-1:0]        lag_q, lag_d;
    logic signed [SUM_W-1:0] r0_q, r0_d;
    logic signed [SUM_W-1:0] best_q, best_d;
    logic [LAG_W-1:0]        best_lag_q, best_lag_d;
    logic                    has_best_q, has_best_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [LAG_W-1:0]        pitch_lag_q, pitch_lag_d;
    logic signed [SUM_W-1:0] peak_sum_q, peak_sum_d;
    logic                    pitch_found_q, pitch_found_d;

    logic                    accept;
    logic [LAG_W-1:0]        beat_lag;
    logic                    thr_ge;

    peak_threshold_cmp #(.THR_NUM(THR_NUM)) u_thr (
        .best (best_d),
        .r0   (r0_d),
        .ge   (thr_ge)
    );

    always_comb begin
        state_d       = state_q;
        lag_d         = lag_q;
        r0_d          = r0_q;
        best_d        = best_q;
        best_lag_d    = best_lag_q;
        has_best_d    = has_best_q;
        out_valid_d   = out_valid_q;
        pitch_lag_d   = pitch_lag_q;
        peak_sum_d    = peak_sum_q;
        pitch_found_d = pitch_found_q;

        accept   = bus.in_valid && in_ready_q;
        beat_lag = (lag_q == '1) ? lag_q : lag_q + 1'b1;

        // in_first always restarts, so IDLE/SEEK/TRACK share the frame-start path
        if (accept && state_q != ST_DONE) begin
            if (bus.in_first) begin
                state_d    = ST_SEEK;
                r0_d       = bus.in_sum;
                lag_d      = '0;
                best_d     = '0;
                best_lag_d = '0;
                has_best_d = 1'b0;
            end else if (state_q != ST_IDLE) begin
                lag_d = beat_lag;
                if (state_q == ST_SEEK) begin
                    if (bus.in_sum < 0) state_d = ST_TRACK;
                end else if (beat_lag >= MIN_L && beat_lag <= MAX_L &&
                             (!has_best_q || bus.in_sum > best_q)) begin
                    best_d     = bus.in_sum;
                    best_lag_d = beat_lag;
                    has_best_d = 1'b1;
                end
            end

            if (bus.in_last && (state_q != ST_IDLE || bus.in_first)) begin
                state_d       = ST_DONE;
                out_valid_d   = 1'b1;
                pitch_lag_d   = has_best_d ? best_lag_d : '0;
                peak_sum_d    = has_best_d ? best_d : '0;
                pitch_found_d = has_best_d && (r0_d > 0) && thr_ge;
            end
        end else if (state_q == ST_DONE && bus.out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            lag_q         <= '0;
            r0_q          <= '0;
            best_q        <= '0;
            best_lag_q    <= '0;
            has_best_q    <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            pitch_lag_q   <= '0;
            peak_sum_q    <= '0;
            pitch_found_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lag_q         <= lag_d;
            r0_q          <= r0_d;
            best_q        <= best_d;
            best_lag_q    <= best_lag_d;
            has_best_q    <= has_best_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            pitch_lag_q   <= pitch_lag_d;
            peak_sum_q    <= peak_sum_d;
            pitch_found_q <= pitch_found_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.pitch_lag   = pitch_lag_q;
    assign bus.peak_sum    = peak_sum_q;
    assign bus.pitch_found = pitch_found_q;
endmodule

// File: tb/tb_autocorr_peak_picker.sv
// tb/tb_autocorr_peak_picker.sv - directed frames with a queued expectation scoreboard
module tb_autocorr_peak_picker;
    import pitch_pkg::*;

    typedef struct {
        int     lag;
        longint sum;
        bit     found;
        string  name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    autocorr_peak_picker_if bus ();

    autocorr_peak_picker #(.MIN_LAG(2), .MAX_LAG(6), .THR_NUM(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Handshake completes on the next posedge, so each result is compared exactly once.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_lag"},   longint'(bus.pitch_lag), longint'(e.lag));
                check({e.name, "_peak"},  longint'(bus.peak_sum),  e.sum);
                check({e.name, "_found"}, longint'(bus.pitch_found), longint'(e.found));
            end
        end
    end

    task automatic send_beat(input longint sum, input bit first, input bit last);
        bit ok;
        int tries;
        bus.in_valid = 1'b1;
        bus.in_sum   = SUM_W'(sum);
        bus.in_first = first;
        bus.in_last  = last;
        ok = 1'b0;
        tries = 0;
        while (!ok && tries < 50) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!ok) check("beat_accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input longint sums[$], input int lag, input longint pk,
                              input bit found, input string name);
        exp_t e;
        e.lag = lag; e.sum = pk; e.found = found; e.name = name;
        sb_q.push_back(e);
        foreach (sums[i]) send_beat(sums[i], i == 0, i == sums.size() - 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        longint pl, ps;
        bit     pf;
        int     t;

        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_lag",       bus.pitch_lag, 0);
        check("rst_peak",      bus.peak_sum, 0);
        check("rst_found",     bus.pitch_found, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame('{1000, 600, -200, -50, 300, 700, 650, 100}, 5, 700, 1'b1, "basic");
        send_frame('{1000, 600, -200, -50, 300, 600, 650, 100}, 6, 650, 1'b1, "late_peak");
        send_frame('{1000, 600, -200, -50, 300, 600, 500, 100}, 5, 600, 1'b0, "below_thr");
        send_frame('{1000, -10, 700, 700, 10, 20, 30, 900}, 2, 700, 1'b1, "tie_maxlag");
        send_frame('{1000, 900, 800, 700}, 0, 0, 1'b0, "no_dip");
        send_frame('{-5, -1, 3, 4}, 3, 4, 1'b0, "neg_r0");
        send_frame('{777}, 0, 0, 1'b0, "one_lag");
        drain();

        // Stray beat in IDLE without in_first must be dropped.
        send_beat(123, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("idle_drop_out_valid", bus.out_valid, 0);

        // Abort: partial frame then in_first restarts.
        begin
            exp_t e;
            e.lag = 5; e.sum = 700; e.found = 1'b1; e.name = "abort";
            sb_q.push_back(e);
            send_beat(1000, 1'b1, 1'b0);
            send_beat(600, 1'b0, 1'b0);
            send_beat(-200, 1'b0, 1'b0);
            foreach (sb_q[i]) begin end
        end
        begin
            longint fr[$] = '{1000, 600, -200, -50, 300, 700, 650, 100};
            foreach (fr[i]) send_beat(fr[i], i == 0, i == fr.size() - 1);
        end
        drain();

        // Backpressure: hold out_ready low and confirm the result is frozen.
        bus.out_ready = 1'b0;
        begin
            exp_t e;
            longint fr[$] = '{1000, -10, 700, 650};
            e.lag = 2; e.sum = 700; e.found = 1'b1; e.name = "stall";
            sb_q.push_back(e);
            foreach (fr[i]) send_beat(fr[i], i == 0, i == fr.size() - 1);
        end
        t = 0;
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("stall_valid_seen", bus.out_valid, 1);
        pl = bus.pitch_lag; ps = bus.peak_sum; pf = bus.pitch_found;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_in_ready",  bus.in_ready, 0);
            check("stall_lag",       bus.pitch_lag, pl);
            check("stall_peak",      bus.peak_sum, ps);
            check("stall_found",     bus.pitch_found, pf);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        // Asynchronous reset mid-frame.
        send_beat(1000, 1'b1, 1'b0);
        send_beat(-3, 1'b0, 1'b0);
        send_beat(800, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_lag",       bus.pitch_lag, 0);
        check("midrst_peak",      bus.peak_sum, 0);
        check("midrst_found",     bus.pitch_found, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Continuation beats of the discarded frame must not produce a result.
        send_beat(900, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_result", bus.out_valid, 0);

        send_frame('{1000, 600, -200, -50, 300, 700, 650, 100}, 5, 700, 1'b1, "post_rst");
        drain();
        check("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
